// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake between the UART receive FIFO and its consumer.
// slave = FIFO side, master = consumer side.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [LVL_W-1:0] fifo_level;

  modport master (output rd_en, input rd_data, input rd_valid, input fifo_level);
  modport slave  (input rd_en, output rd_data, output rd_valid, output fifo_level);
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver (LSB first) feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity check; default is 8N1.
//
// state    | meaning
// ST_IDLE  | waiting for a low level on the synchronised line
// ST_START | confirming the start bit at its midpoint
// ST_DATA  | sampling 8 data bits, LSB first
// ST_PARITY| sampling the even-parity bit (parity build only)
// ST_STOP  | sampling the stop bit, pushing or flagging the frame
// ST_BREAK | line held low after a framing error; wait for it to go high
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          uart_rxd,
  uart_rx_fifo_if.slave rd_if,
  output logic          frame_err,
  output logic          par_err,
  output logic          overflow,
  input  logic          ovf_clr
);
  localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rxd_meta, r_rxd_sync;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_os_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_push, r_frame_err, r_overflow;
  logic             w_tick, w_sample, w_restart, w_push_req, w_ferr;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_empty, w_full, w_pop, w_wr;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, r_par_err, w_perr, w_par_ok;
  assign w_par_ok = ~^{r_shift, r_par_bit};
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // sample fires on the terminal tick of the per-bit down-counter
  assign w_tick   = (r_div_cnt == '0);
  assign w_sample = w_tick && (r_os_cnt == 4'd0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_push_req  = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!r_rxd_sync) begin
          w_state_nxt = ST_START;
          w_restart   = 1'b1;
        end
      end
      ST_START: begin
        if (w_sample) w_state_nxt = r_rxd_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_sample && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_sample) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_sample) begin
          if (!r_rxd_sync) begin
            w_ferr      = 1'b1;
            w_state_nxt = ST_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (!w_par_ok) begin
            w_perr      = 1'b1;
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_push_req  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (r_rxd_sync) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // counters restart on start detection so the first sample lands mid start bit
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_div_cnt <= '0;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_restart) begin
      r_div_cnt <= DIV_W'(DIV - 1);
      r_os_cnt  <= 4'd7;
      r_bit_cnt <= '0;
    end else begin
      r_div_cnt <= w_tick ? DIV_W'(DIV - 1) : r_div_cnt - DIV_W'(1);
      if (w_tick) r_os_cnt <= (r_os_cnt == 4'd0) ? 4'd15 : r_os_cnt - 4'd1;
      if ((r_state == ST_DATA) && w_sample) begin
        r_shift   <= {r_rxd_sync, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_par_bit <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if ((r_state == ST_PARITY) && w_sample) r_par_bit <= r_rxd_sync;
      r_par_err <= w_perr;
    end
  end
  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop   = rd_if.rd_en && !w_empty;
  assign w_wr    = r_push && (!w_full || w_pop);

  // r_shift is stable for hundreds of cycles after the stop sample
  always_ff @(posedge clk_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
    end else begin
      r_push      <= w_push_req;
      r_frame_err <= w_ferr;
      if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (ovf_clr)               r_overflow <= 1'b0;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rd_if.rd_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign rd_if.rd_valid   = !w_empty;
  assign rd_if.fifo_level = r_level;
  assign frame_err        = r_frame_err;
  assign overflow         = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 50 MHz / 115200 baud (432 clocks per bit).
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_fifo;
  localparam int BIT  = 432;
  localparam int STOP = 230;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic ovf_clr = 1'b0;
  logic frame_err, par_err, overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr = 0;
  int n_perr = 0;

  uart_rx_fifo_if #(.FIFO_DEPTH(16)) rd_if ();

  uart_rx_fifo #(.CLK_HZ(50000000), .BAUD(115200), .FIFO_DEPTH(16)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .uart_rxd      (uart_rxd),
    .rd_if         (rd_if.slave),
    .frame_err     (frame_err),
    .par_err       (par_err),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
  );

  always #10 clk_clk = ~clk_clk;

  always @(negedge clk_clk) begin
    if (frame_err) n_ferr = n_ferr + 1;
    if (par_err)   n_perr = n_perr + 1;
  end

  // Drives one frame starting at a negedge; pop_at asserts rd_en for one
  // cycle that many clocks into the stop bit (negative = never).
  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop_v, input int stop_len, input int pop_at);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (BIT) @(negedge clk_clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ par_flip;
    repeat (BIT) @(negedge clk_clk);
`else
    begin
      logic unused_par_flip;
      unused_par_flip = par_flip;
    end
`endif
    uart_rxd = stop_v;
    for (int c = 0; c < stop_len; c++) begin
      rd_if.rd_en = (c == pop_at);
      @(negedge clk_clk);
    end
    rd_if.rd_en = 1'b0;
  endtask

  task automatic pop_one();
    rd_if.rd_en = 1'b1;
    @(negedge clk_clk);
    rd_if.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_clk);
    n_checks++; if (rd_if.rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_if.rd_valid); end
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", rd_if.fifo_level); end
    n_checks++; if (rd_if.rd_data !== 8'h00) begin n_errors++; $display("FAIL reset_rd_data: got %h want 00", rd_if.rd_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_checks++; if (par_err !== 1'b0) begin n_errors++; $display("FAIL reset_par_err: got %b want 0", par_err); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    reset_reset_n = 1'b1;
    repeat (10) @(negedge clk_clk);
  endtask

  task automatic test_single();
    // stop-bit sample lands 219 clocks into the stop bit; write one clock later
    send_frame(8'h55, 1'b0, 1'b1, 219, -1);
    n_checks++; if (rd_if.rd_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid: got %b want 0", rd_if.rd_valid); end
    repeat (2) @(negedge clk_clk);
    n_checks++; if (rd_if.rd_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b want 1", rd_if.rd_valid); end
    n_checks++; if (rd_if.rd_data !== 8'h55) begin n_errors++; $display("FAIL single_data: got %h want 55", rd_if.rd_data); end
    n_checks++; if (rd_if.fifo_level !== 5'd1) begin n_errors++; $display("FAIL single_level: got %0d want 1", rd_if.fifo_level); end
    repeat (10) @(negedge clk_clk);
    pop_one();
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL single_pop_level: got %0d want 0", rd_if.fifo_level); end
    n_checks++; if (rd_if.rd_valid !== 1'b0) begin n_errors++; $display("FAIL single_pop_valid: got %b want 0", rd_if.rd_valid); end
    pop_one();
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL empty_pop_level: got %0d want 0", rd_if.fifo_level); end
  endtask

  task automatic test_glitch();
    int f0, p0;
    f0 = n_ferr; p0 = n_perr;
    uart_rxd = 1'b0;
    repeat (81) @(negedge clk_clk);
    uart_rxd = 1'b1;
    repeat (400) @(negedge clk_clk);
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL glitch_level: got %0d want 0", rd_if.fifo_level); end
    n_checks++; if (n_ferr != f0) begin n_errors++; $display("FAIL glitch_frame_err: got %0d pulses want 0", n_ferr - f0); end
    n_checks++; if (n_perr != p0) begin n_errors++; $display("FAIL glitch_par_err: got %0d pulses want 0", n_perr - p0); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = n_ferr;
    send_frame(8'hA3, 1'b0, 1'b0, BIT + 2 * BIT, -1);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk_clk);
    n_checks++; if (n_ferr - f0 != 1) begin n_errors++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr - f0); end
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL ferr_level: got %0d want 0", rd_if.fifo_level); end
    send_frame(8'h12, 1'b0, 1'b1, STOP, -1);
    n_checks++; if (rd_if.fifo_level !== 5'd1) begin n_errors++; $display("FAIL after_break_level: got %0d want 1", rd_if.fifo_level); end
    n_checks++; if (rd_if.rd_data !== 8'h12) begin n_errors++; $display("FAIL after_break_data: got %h want 12", rd_if.rd_data); end
    n_checks++; if (n_ferr - f0 != 1) begin n_errors++; $display("FAIL after_break_ferr: got %0d want 1", n_ferr - f0); end
  endtask

  // FIFO holds 0x12 on entry; fill to 16, push+pop when full, then drop one.
  task automatic test_full_overflow();
    for (int k = 1; k < 16; k++) send_frame(8'(k), 1'b0, 1'b1, STOP, -1);
    n_checks++; if (rd_if.fifo_level !== 5'd16) begin n_errors++; $display("FAIL full_level: got %0d want 16", rd_if.fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
    n_checks++; if (rd_if.rd_data !== 8'h12) begin n_errors++; $display("FAIL full_head: got %h want 12", rd_if.rd_data); end
    send_frame(8'h10, 1'b0, 1'b1, STOP, 219);
    n_checks++; if (rd_if.fifo_level !== 5'd16) begin n_errors++; $display("FAIL pushpop_level: got %0d want 16", rd_if.fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
    n_checks++; if (rd_if.rd_data !== 8'h01) begin n_errors++; $display("FAIL pushpop_head: got %h want 01", rd_if.rd_data); end
    send_frame(8'h11, 1'b0, 1'b1, STOP, -1);
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_checks++; if (rd_if.fifo_level !== 5'd16) begin n_errors++; $display("FAIL ovf_level: got %0d want 16", rd_if.fifo_level); end
    repeat (5) @(negedge clk_clk);
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk_clk);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    for (int k = 1; k < 16; k++) begin
      logic [7:0] exp;
      exp = 8'(k);
      n_checks++; if (rd_if.rd_data !== exp) begin n_errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, rd_if.rd_data, exp); end
      pop_one();
    end
    n_checks++; if (rd_if.fifo_level !== 5'd1) begin n_errors++; $display("FAIL drain_level: got %0d want 1", rd_if.fifo_level); end
    n_checks++; if (rd_if.rd_data !== 8'h10) begin n_errors++; $display("FAIL drain_last: got %h want 10", rd_if.rd_data); end
  endtask

  task automatic test_reset_mid();
    uart_rxd = 1'b0;
    repeat (600) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk_clk);
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL rst_mid_level: got %0d want 0", rd_if.fifo_level); end
    n_checks++; if (rd_if.rd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_valid: got %b want 0", rd_if.rd_valid); end
    n_checks++; if (rd_if.rd_data !== 8'h00) begin n_errors++; $display("FAIL rst_mid_data: got %h want 00", rd_if.rd_data); end
    reset_reset_n = 1'b1;
    repeat (20) @(negedge clk_clk);
    send_frame(8'h7E, 1'b0, 1'b1, STOP, -1);
    n_checks++; if (rd_if.fifo_level !== 5'd1) begin n_errors++; $display("FAIL rst_7e_level: got %0d want 1", rd_if.fifo_level); end
    n_checks++; if (rd_if.rd_data !== 8'h7E) begin n_errors++; $display("FAIL rst_7e_data: got %h want 7e", rd_if.rd_data); end
    pop_one();
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL rst_7e_pop: got %0d want 0", rd_if.fifo_level); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int p0, f0;
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'h7E, 1'b1, 1'b1, STOP, -1);
    repeat (5) @(negedge clk_clk);
    n_checks++; if (n_perr - p0 != 1) begin n_errors++; $display("FAIL par_err_pulses: got %0d want 1", n_perr - p0); end
    n_checks++; if (n_ferr != f0) begin n_errors++; $display("FAIL par_no_ferr: got %0d want 0", n_ferr - f0); end
    n_checks++; if (rd_if.fifo_level !== 5'd0) begin n_errors++; $display("FAIL par_level: got %0d want 0", rd_if.fifo_level); end
`else
    n_checks++; if (n_perr != 0) begin n_errors++; $display("FAIL par_err_8n1: got %0d pulses want 0", n_perr); end
`endif
  endtask

  initial begin
    rd_if.rd_en = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_full_overflow();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
